fir_alu: RTL and testbench
==========================

Name: fir_alu

Overview:
- Signed multiply-accumulate (MAC) slice for the FIR filter datapath.
- Computes totalSumOut = totalSumIn + inputX * inputB.
- inputX is a sample and inputB is a coefficient.
- Taps are chained by feeding one slice's totalSumOut into the next slice's totalSumIn.
- The result is registered, so latency is one clock.

Parameters:
- X_WIDTH, 16, sample width in bits (signed two's complement).
- B_WIDTH, 16, coefficient width in bits (signed two's complement).
- ACC_WIDTH, 39, accumulator width in bits: 32-bit product plus 7 guard bits, enough for 128 taps.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  qualifies inputX, inputB and totalSumIn this cycle.
- inputX  in  X_WIDTH  signed sample.
- inputB  in  B_WIDTH  signed coefficient.
- totalSumIn  in  ACC_WIDTH  signed partial sum from the previous tap.
- totalSumOut  out  ACC_WIDTH  signed registered result.
- out_valid  out  1  totalSumOut holds a new result.
- ovf  out  1  sticky overflow flag; present only with FIR_ALU_SAT_EN, otherwise not declared.

Behaviour:
- All state updates on the rising edge of clk; there are no asynchronous paths to the outputs.
- Reset: while rst=1 at a clock edge, totalSumOut<=0, out_valid<=0 and ovf<=0. rst has priority over in_valid.
- Product: full-precision signed product, X_WIDTH+B_WIDTH bits.
  - Sign-extend the product to ACC_WIDTH before the add.
  - Perform the addition at ACC_WIDTH+1 bits so that overflow can be detected.
- Accept cycle (in_valid=1, rst=0):
  - totalSumOut <= truncated or saturated sum (see Optional Feature).
  - out_valid <= 1.
- Idle cycle (in_valid=0, rst=0):
  - totalSumOut holds its previous value.
  - out_valid <= 0.
- Latency: a result is visible one cycle after in_valid is sampled.
- Throughput: one operation per cycle, back-to-back, with no stall and no backpressure.
- Extreme operands: inputX = inputB = -2^(N-1) gives +2^30 for 16-bit widths. This must be exact, with no 32-bit wrap.
- Overflow without the feature: two's-complement wrap at ACC_WIDTH.
- Reset mid-stream: an in-flight result is discarded, and out_valid is 0 on the cycle after reset.
- Inputs are fully combinational into a single register stage; there are no internal multicycle paths.

Optional Feature:
- Macro: FIR_ALU_SAT_EN.
- Defined:
  - A sum exceeding the ACC_WIDTH signed range clamps to +(2^(ACC_WIDTH-1))-1 or -2^(ACC_WIDTH-1).
  - Port ovf is present. It is set on any clamped accept cycle and cleared only by rst.
- Undefined:
  - Plain wrap-around arithmetic.
  - Port ovf is not declared.

Decomposition:
- Package fir_pkg:
  - constants X_WIDTH_D=16, B_WIDTH_D=16, ACC_WIDTH_D=39;
  - typedefs sample_t, coef_t, acc_t;
  - constants ACC_MAX and ACC_MIN.
- Optional sub-module fir_alu_sat: pure combinational clamp from ACC_WIDTH+1 to ACC_WIDTH bits, with an overflow flag.
- The multiply-add itself stays in fir_alu.

Test Plan:
- Basic: rst for 2 cycles, then in_valid=1, inputX=1, inputB=2, totalSumIn=0. The next cycle gives totalSumOut=2 and out_valid=1. Hold in_valid=0 for 3 cycles; totalSumOut stays 2 and out_valid=0.
- Signs: X=-3, B=7, in=100 -> 79. X=-32768, B=-32768, in=0 -> 1073741824.
- Back-to-back: 4 consecutive valid ops (X=1..4, B=10, in=0). The outputs are 10, 20, 30, 40 on consecutive cycles with out_valid continuously high.
- Chaining: feed the output of one op into totalSumIn of the next (taps X={1,2,3}, B={5,-1,4}). The final result is 15.
- Overflow: totalSumIn = 2^38-1, X=1, B=1.
  - Without FIR_ALU_SAT_EN: -2^38.
  - With FIR_ALU_SAT_EN: 2^38-1 and ovf=1.
- Reset mid-op: assert rst in the same cycle as a valid op. The next cycle gives totalSumOut=0, out_valid=0, ovf=0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared widths, datapath types and accumulator range limits for the FIR MAC slice.
package fir_pkg;

  localparam int X_WIDTH_D   = 16;
  localparam int B_WIDTH_D   = 16;
  localparam int ACC_WIDTH_D = 39;

  typedef logic signed [X_WIDTH_D-1:0]   sample_t;
  typedef logic signed [B_WIDTH_D-1:0]   coef_t;
  typedef logic signed [ACC_WIDTH_D-1:0] acc_t;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_WIDTH_D-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_WIDTH_D-1){1'b0}}};

endpackage

// File: rtl/fir_alu_sat.sv
// Combinational clamp of a one-bit-wider signed sum back into the accumulator range.
// Only instantiated when FIR_ALU_SAT_EN is defined.
module fir_alu_sat
  import fir_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_D
) (
  input  logic signed [ACC_WIDTH:0]   sum_i,
  output logic signed [ACC_WIDTH-1:0] sat_o,
  output logic                        ovf_o
);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Top two bits disagree exactly when the sum left the ACC_WIDTH range.
  always_comb begin
    sat_o = sum_i[ACC_WIDTH-1:0];
    ovf_o = 1'b0;
    if (sum_i[ACC_WIDTH] != sum_i[ACC_WIDTH-1]) begin
      ovf_o = 1'b1;
      if (sum_i[ACC_WIDTH]) begin
        sat_o = SAT_MIN;
      end else begin
        sat_o = SAT_MAX;
      end
    end else begin
      sat_o = sum_i[ACC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fir_alu.sv
// Signed MAC slice: totalSumOut <= totalSumIn + inputX * inputB, one cycle latency.
// Define FIR_ALU_SAT_EN for saturating accumulation and a sticky ovf output.
module fir_alu
  import fir_pkg::*;
#(
  parameter int X_WIDTH   = X_WIDTH_D,
  parameter int B_WIDTH   = B_WIDTH_D,
  parameter int ACC_WIDTH = ACC_WIDTH_D
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [X_WIDTH-1:0]   inputX,
  input  logic signed [B_WIDTH-1:0]   inputB,
  input  logic signed [ACC_WIDTH-1:0] totalSumIn,
  output logic signed [ACC_WIDTH-1:0] totalSumOut,
`ifdef FIR_ALU_SAT_EN
  output logic                        ovf,
`endif
  output logic                        out_valid
);

  localparam int PW = X_WIDTH + B_WIDTH;

  logic signed [PW-1:0]        prod_s;
  logic signed [ACC_WIDTH:0]   prod_ext_s;
  logic signed [ACC_WIDTH:0]   sin_ext_s;
  logic signed [ACC_WIDTH:0]   sum_wide_s;
  logic signed [ACC_WIDTH-1:0] next_sum_s;
  logic signed [ACC_WIDTH-1:0] sum_d, sum_q;
  logic                        valid_d, valid_q;

  // Full-precision product; both operands signed so -2^15 * -2^15 stays exact.
  assign prod_s     = inputX * inputB;
  assign prod_ext_s = {{(ACC_WIDTH+1-PW){prod_s[PW-1]}}, prod_s};
  assign sin_ext_s  = {totalSumIn[ACC_WIDTH-1], totalSumIn};
  assign sum_wide_s = prod_ext_s + sin_ext_s;

`ifdef FIR_ALU_SAT_EN
  logic sat_ovf_s;
  logic ovf_d, ovf_q;

  fir_alu_sat #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat (
    .sum_i (sum_wide_s),
    .sat_o (next_sum_s),
    .ovf_o (sat_ovf_s)
  );

  // Sticky: once a clamped result is accepted only rst clears it.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = ovf_q | sat_ovf_s;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign next_sum_s = sum_wide_s[ACC_WIDTH-1:0];
`endif

  // Accept loads the new sum; idle holds the sum and drops valid.
  always_comb begin
    sum_d   = sum_q;
    valid_d = 1'b0;
    if (in_valid) begin
      sum_d   = next_sum_s;
      valid_d = 1'b1;
    end else begin
      sum_d   = sum_q;
      valid_d = 1'b0;
    end
  end

  // Result and valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign totalSumOut = sum_q;
  assign out_valid   = valid_q;

endmodule

// File: tb/tb_fir_alu.sv
// Self-checking bench for fir_alu: directed test-plan cases plus randomized traffic
// against an arithmetic reference model. Honors FIR_ALU_SAT_EN.
module tb_fir_alu;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] inputX;
  logic signed [15:0] inputB;
  logic signed [38:0] totalSumIn;
  logic signed [38:0] totalSumOut;
  logic               out_valid;
`ifdef FIR_ALU_SAT_EN
  logic               ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  longint exp_sum;
  bit     exp_valid;
  bit     exp_ovf;

  localparam longint MAXV = (64'sd1 <<< 38) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< 38);

  fir_alu dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .inputX      (inputX),
    .inputB      (inputB),
    .totalSumIn  (totalSumIn),
    .totalSumOut (totalSumOut),
`ifdef FIR_ALU_SAT_EN
    .ovf         (ovf),
`endif
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint wrap39(input longint s);
    longint m;
    m = s & ((64'sd1 <<< 39) - 64'sd1);
    if (m > MAXV) m = m - (64'sd1 <<< 39);
    return m;
  endfunction

  // One clock: drive inputs, advance the reference model, compare outputs.
  task automatic cycle(input bit r, input bit v, input longint x, input longint b, input longint s);
    longint full;
    longint sv;
    sv = s;
    rst        = r;
    in_valid   = v;
    inputX     = x[15:0];
    inputB     = b[15:0];
    totalSumIn = sv[38:0];
    @(posedge clk);
    if (r) begin
      exp_sum = 0; exp_valid = 1'b0; exp_ovf = 1'b0;
    end else if (v) begin
      full = s + x * b;
`ifdef FIR_ALU_SAT_EN
      if (full > MAXV) begin exp_sum = MAXV; exp_ovf = 1'b1; end
      else if (full < MINV) begin exp_sum = MINV; exp_ovf = 1'b1; end
      else exp_sum = full;
`else
      exp_sum = wrap39(full);
`endif
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    #1;
    check_val("sum", longint'(totalSumOut), exp_sum);
    check_val("valid", longint'(out_valid), longint'(exp_valid));
`ifdef FIR_ALU_SAT_EN
    check_val("ovf", longint'(ovf), longint'(exp_ovf));
`endif
  endtask

  initial begin
    longint acc;
    longint rs;
    longint xs [3];
    longint bs [3];
    xs = '{1, 2, 3};
    bs = '{5, -1, 4};
    rst = 1'b1; in_valid = 1'b0; inputX = '0; inputB = '0; totalSumIn = '0;
    exp_sum = 0; exp_valid = 1'b0; exp_ovf = 1'b0;

    // Basic
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check_val("reset_sum", longint'(totalSumOut), 0);
    cycle(0, 1, 1, 2, 0);
    check_val("basic_sum", longint'(totalSumOut), 2);
    check_val("basic_valid", longint'(out_valid), 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 9, 9, 9);
      check_val("idle_hold", longint'(totalSumOut), 2);
      check_val("idle_valid", longint'(out_valid), 0);
    end

    // Signs and extreme operands
    cycle(0, 1, -3, 7, 100);
    check_val("signs", longint'(totalSumOut), 79);
    cycle(0, 1, -32768, -32768, 0);
    check_val("extreme", longint'(totalSumOut), 64'sd1073741824);

    // Back-to-back
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 1, i, 10, 0);
      check_val("b2b_sum", longint'(totalSumOut), 10 * i);
      check_val("b2b_valid", longint'(out_valid), 1);
    end

    // Chaining through totalSumIn
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, xs[i], bs[i], acc);
      acc = exp_sum;
    end
    check_val("chain", longint'(totalSumOut), 15);

    // Overflow at the positive edge of the range
    cycle(0, 1, 1, 1, MAXV);
`ifdef FIR_ALU_SAT_EN
    check_val("ovf_sat_sum", longint'(totalSumOut), MAXV);
    check_val("ovf_flag", longint'(ovf), 1);
    cycle(0, 1, 1, 1, 0);
    check_val("ovf_sticky", longint'(ovf), 1);
`else
    check_val("ovf_wrap_sum", longint'(totalSumOut), MINV);
`endif

    // Reset alongside a valid op
    cycle(1, 1, 5, 5, 0);
    check_val("rst_mid_sum", longint'(totalSumOut), 0);
    check_val("rst_mid_valid", longint'(out_valid), 0);
`ifdef FIR_ALU_SAT_EN
    check_val("rst_mid_ovf", longint'(ovf), 0);
`endif

    // Randomized traffic, including sums near both range limits
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(3, 0))
        0: rs = MAXV - longint'($urandom_range(1 << 20, 0));
        1: rs = MINV + longint'($urandom_range(1 << 20, 0));
        default: rs = wrap39({longint'($urandom), 32'($urandom)});
      endcase
      cycle(($urandom_range(31, 0) == 0), ($urandom_range(3, 0) != 0),
            longint'($signed(16'($urandom))), longint'($signed(16'($urandom))), rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
